// File: rtl/aes_pkg.sv
// Shared Rijndael ShiftRows helpers: legal column counts, row offsets and byte placement.
package aes_pkg;

   localparam int COL_W = 32;

   function automatic bit nb_is_legal(int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   function automatic int state_w(int nb);
      return COL_W * nb;
   endfunction

   // Wide blocks (8 columns) use a larger offset for rows 2 and 3.
   function automatic int row_shift(int nb, int r);
      if (nb == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   // Byte k = r + 4c sits MSB-first in the column-major state vector.
   function automatic int byte_lsb(int nb, int r, int c);
      return state_w(nb) - 8 - 8 * (r + 4 * c);
   endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows (INV=0) or InvShiftRows (INV=1) byte permutation.
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter int NB  = 4,
   parameter bit INV = 1'b0
) (
   input  logic [COL_W*NB-1:0] din,
   output logic [COL_W*NB-1:0] dout
);

   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int SH  = row_shift(NB, r);
         // Source column wraps modulo NB, not modulo 4.
         localparam int SRC = INV ? (c + NB - SH) % NB : (c + SH) % NB;
         assign dout[byte_lsb(NB, r, c) +: 8] = din[byte_lsb(NB, r, SRC) +: 8];
      end
   end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows stage with a 2-entry elastic output buffer.
// Define AES_SHIFT_ROWS_INV_EN to compile in the per-transaction InvShiftRows path.
module aes_shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COL_W*NB-1:0]    in_data,
   input  logic                   in_inv,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [COL_W*NB-1:0]    out_data,
   output logic                   out_inv,
   output logic [TAG_W-1:0]       out_tag
);

   localparam int W = state_w(NB);

   if (!nb_is_legal(NB)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("aes_shift_rows_pipe: TAG_W must be at least 1");
   end

   logic [W-1:0] fwd_data;
   logic [W-1:0] perm_data;
   logic         new_inv;

   shift_rows_perm #(.NB(NB), .INV(1'b0)) u_fwd (
      .din  (in_data),
      .dout (fwd_data)
   );

`ifdef AES_SHIFT_ROWS_INV_EN
   logic [W-1:0] inv_data;

   shift_rows_perm #(.NB(NB), .INV(1'b1)) u_inv (
      .din  (in_data),
      .dout (inv_data)
   );

   assign perm_data = in_inv ? inv_data : fwd_data;
   assign new_inv   = in_inv;
`else
   logic unused_inv;

   assign unused_inv = in_inv;
   assign perm_data  = fwd_data;
   assign new_inv    = 1'b0;
`endif

   logic [1:0]       count;
   logic [W-1:0]     data_q [2];
   logic             inv_q  [2];
   logic [TAG_W-1:0] tag_q  [2];
   logic             push;
   logic             pop;

   assign in_ready  = (count != 2'd2) && !reset;
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_data  = data_q[0];
   assign out_inv   = inv_q[0];
   assign out_tag   = tag_q[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            inv_q[i]  <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else begin
         if (pop) begin
            data_q[0] <= data_q[1];
            inv_q[0]  <= inv_q[1];
            tag_q[0]  <= tag_q[1];
            data_q[1] <= '0;
            inv_q[1]  <= 1'b0;
            tag_q[1]  <= '0;
         end
         // The new entry lands in whichever slot is the tail after any pop.
         if (push) begin
            if (count == 2'd0 || (count == 2'd1 && pop)) begin
               data_q[0] <= perm_data;
               inv_q[0]  <= new_inv;
               tag_q[0]  <= in_tag;
            end else begin
               data_q[1] <= perm_data;
               inv_q[1]  <= new_inv;
               tag_q[1]  <= in_tag;
            end
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: doc/aes_shift_rows_pipe.md
# aes_shift_rows_pipe

- Parametrised, registered Rijndael ShiftRows / InvShiftRows stage with a valid/ready handshake and a 2-entry elastic output buffer.
- Supports block widths of 4, 6 or 8 columns, so the same block serves AES-128 and wider Rijndael variants.
- Carries a per-transaction mode bit and a user tag alongside the data.
- Sits between SubBytes and MixColumns in the pipelined round datapath and decouples backpressure from downstream stages.

## Interface
- `NB`, 4: state columns; legal values 4, 6, 8; any other value is an elaboration error.
- `TAG_W`, 4: width of the sideband tag; minimum 1.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input transaction present.
- `in_ready` out 1: block can accept this cycle.
- `in_data` in 32*NB: state; column-major; byte k = r+4c at bits [32*NB-1-8k -: 8].
- `in_inv` in 1: 1 = InvShiftRows, 0 = ShiftRows.
- `in_tag` in TAG_W: passed through unchanged.
- `out_valid` out 1: output transaction present.
- `out_ready` in 1: downstream accepts.
- `out_data` out 32*NB: permuted state.
- `out_inv` out 1: mode used for this result.
- `out_tag` out TAG_W: tag of this result.

## Operation
- Row offsets:
  - NB=4 or 6: rows 0..3 shift by 0,1,2,3.
  - NB=8: rows 0..3 shift by 0,1,3,4.
- Forward: out(r,c) = in(r, (c+shift(r)) mod NB).
- Inverse: out(r,c) = in(r, (c-shift(r)) mod NB). Indices wrap modulo NB, never modulo 4.
- Permutation is applied on entry; the buffer stores permuted data, mode and tag as one entry.
- Buffer: 2 entries, FIFO order, occupancy `count` in 0..2.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != 2) && !reset; driven from registered state only, with no combinational path from out_ready.
- out_valid = (count != 0). out_data, out_inv and out_tag show the head entry.
- Push and pop in the same cycle: count unchanged, the head advances and the new entry is appended.
- count==2 with out_ready=1: the pop occurs, no push, count becomes 1.
- Head output holds stable while out_valid && !out_ready.
- Reset (any cycle, including mid-stream):
  - count=0; all buffered entries discarded.
  - out_valid=0, out_data=0, out_inv=0, out_tag=0.
  - in_ready=0 while reset is high; in_ready=1 the first cycle after release.

## Timing
- Latency: input accepted in cycle N → out_valid at cycle N+1 when the buffer was empty or was popped in cycle N.
- Throughput: 1 transaction/cycle sustained with out_ready held high.
- Mode and tag are sampled with the data; mixed-mode back-to-back traffic needs no bubble.
- After out_ready falls: at most 2 further inputs are accepted, then in_ready deasserts the cycle after the second accept.

## Configuration
- `AES_SHIFT_ROWS_INV_EN` defined: inverse path compiled in; in_inv selects the direction per transaction; out_inv reflects it.
- Not defined:
  - Forward-only permutation; in_inv is ignored and out_inv reads 0.
  - Port list is unchanged.

## Structure
- Shared package `aes_pkg` holds:
  - Legal NB values.
  - A row-shift offset function of (NB, row).
  - The byte-index helper for (r,c) to bit offset.
  - The state width constant 32*NB.
- Sub-module `shift_rows_perm`, purely combinational, parameters NB and INV: one instance for the forward direction, one for the inverse when the macro is defined, muxed by in_inv.
- The buffer and control live in the top module.

## Test plan
- NB=4, forward, in_data=d42711aee0bf98f1b8b45de51e415230 → out_data=d4bf5d30e0b452aeb84111f11e2798e5 one cycle later.
- NB=4, in_data=000102030405060708090a0b0c0d0e0f:
  - Forward → 00050a0f04090e03080d02070c01060b.
  - Feeding that result back with in_inv=1 (macro on) → original value.
  - Tags 3 then 4 appear in order.
- NB=8, forward, in_data bytes 00..1f ascending → the top 32 bits of out_data equal 00050e13. Check all 32 bytes against a reference model.
- Backpressure, out_ready=0, in_valid=1 with tags 1,2,3:
  - Tags 1 and 2 are accepted; in_ready=0 thereafter.
  - Output holds tag 1 stable.
  - After out_ready=1, tags 1,2,3 exit on consecutive cycles.
- Reset mid-stream with count=2: assert reset one cycle → out_valid=0 and all outputs 0 next cycle; in_ready=1 after release; the discarded entries never appear.
- Random valid/ready over 10k transactions, mixed modes: no loss, no duplication, order preserved, results match the model.
